// File: rtl/scalar_mult_ctrl_pkg.sv
// Shared definitions for the Ed25519 scalar-multiplication sequencer:
// FSM state encoding, point geometry and a small state-decoding helper.
package scalar_mult_ctrl_pkg;

  localparam int NUM_COORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DBL_ISS  = 3'd1,
    S_DBL_WAIT = 3'd2,
    S_ADD_ISS  = 3'd3,
    S_ADD_WAIT = 3'd4,
    S_NEXT     = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  function automatic logic isIssue(input state_t s);
    return (s == S_DBL_ISS) || (s == S_ADD_ISS);
  endfunction

endpackage

// File: rtl/scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer computing R = k*B in extended coordinates,
// time-sharing one external point_add for both doubling (A+A) and addition (A+B).
module scalar_mult_ctrl
  import scalar_mult_ctrl_pkg::*;
#(
  parameter int NBITS = 256,
  parameter int W     = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] k,
  input  logic [W-1:0]     bx,
  input  logic [W-1:0]     by,
  input  logic [W-1:0]     bz,
  input  logic [W-1:0]     bt,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     rx,
  output logic [W-1:0]     ry,
  output logic [W-1:0]     rz,
  output logic [W-1:0]     rt,
  output logic             pa_start,
  output logic [W-1:0]     pa_x1,
  output logic [W-1:0]     pa_y1,
  output logic [W-1:0]     pa_z1,
  output logic [W-1:0]     pa_t1,
  output logic [W-1:0]     pa_x2,
  output logic [W-1:0]     pa_y2,
  output logic [W-1:0]     pa_z2,
  output logic [W-1:0]     pa_t2,
  input  logic             pa_done,
  input  logic [W-1:0]     pa_x3,
  input  logic [W-1:0]     pa_y3,
  input  logic [W-1:0]     pa_z3,
  input  logic [W-1:0]     pa_t3
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CTR_INIT = CW'(NBITS - 1);

  typedef logic [NUM_COORDS-1:0][W-1:0] point_t;

  // Coordinate order inside a point_t is {T, Z, Y, X}; neutral element is (0,1,1,0)
  localparam point_t NEUTRAL = {W'(0), W'(1), W'(1), W'(0)};

  state_t         r_state;
  state_t         w_next;
  logic [NBITS-1:0] r_k;
  logic [CW-1:0]  r_ctr;
  point_t         r_a;
  point_t         r_b;
  point_t         r_op1;
  point_t         r_op2;
  point_t         r_r;
  point_t         w_bIn;
  point_t         w_pa3;
  logic           w_kBit;

  assign w_bIn  = {bt, bz, by, bx};
  assign w_pa3  = {pa_t3, pa_z3, pa_y3, pa_x3};
  assign w_kBit = r_k[r_ctr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_DBL_ISS;
      S_DBL_ISS:  w_next = S_DBL_WAIT;
      S_DBL_WAIT: if (pa_done) w_next = w_kBit ? S_ADD_ISS : S_NEXT;
      S_ADD_ISS:  w_next = S_ADD_WAIT;
      S_ADD_WAIT: if (pa_done) w_next = S_NEXT;
      S_NEXT:     w_next = (r_ctr == '0) ? S_FIN : S_DBL_ISS;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_FIN);
    pa_start = isIssue(r_state);
  end

  // Operands are registered on entry to an issue state so they stay frozen for the whole wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_ctr <= CTR_INIT;
      r_a   <= NEUTRAL;
      r_b   <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_r   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k   <= k;
            r_b   <= w_bIn;
            r_a   <= NEUTRAL;
            r_ctr <= CTR_INIT;
            r_op1 <= NEUTRAL;
            r_op2 <= NEUTRAL;
          end
        end
        S_DBL_WAIT: begin
          if (pa_done) begin
            r_a <= w_pa3;
            if (w_kBit) begin
              r_op1 <= w_pa3;
              r_op2 <= r_b;
            end
          end
        end
        S_ADD_WAIT: begin
          if (pa_done) r_a <= w_pa3;
        end
        S_NEXT: begin
          if (r_ctr == '0) begin
            r_r <= r_a;
          end else begin
            r_ctr <= r_ctr - CW'(1);
            r_op1 <= r_a;
            r_op2 <= r_a;
          end
        end
        default: ;
      endcase
    end
  end

  assign {rt, rz, ry, rx}             = r_r;
  assign {pa_t1, pa_z1, pa_y1, pa_x1} = r_op1;
  assign {pa_t2, pa_z2, pa_y2, pa_x2} = r_op2;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Self-checking bench for scalar_mult_ctrl against an additive point_add stub
// (fixed latency, result = op1 + op2 per coordinate) and a closed-form reference.
module tb_scalar_mult_ctrl;

  localparam int NBITS   = 256;
  localparam int W       = 256;
  localparam int LAT     = 5;
  localparam int TIMEOUT = 6000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NBITS-1:0] k;
  logic [W-1:0]     bx, by, bz, bt;
  logic             busy, done;
  logic [W-1:0]     rx, ry, rz, rt;
  logic             pa_start;
  logic [W-1:0]     pa_x1, pa_y1, pa_z1, pa_t1;
  logic [W-1:0]     pa_x2, pa_y2, pa_z2, pa_t2;
  logic             pa_done;
  logic [W-1:0]     pa_x3, pa_y3, pa_z3, pa_t3;

  int  checkCount = 0;
  int  failCount  = 0;
  int  stubCnt    = 0;
  int  stubCalls  = 0;
  int  protoErr   = 0;
  logic stubDone  = 1'b0;
  logic strayDone = 1'b0;

  always #5 clk = ~clk;

  scalar_mult_ctrl #(.NBITS(NBITS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k),
    .bx(bx), .by(by), .bz(bz), .bt(bt),
    .busy(busy), .done(done),
    .rx(rx), .ry(ry), .rz(rz), .rt(rt),
    .pa_start(pa_start),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_z1(pa_z1), .pa_t1(pa_t1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_z2(pa_z2), .pa_t2(pa_t2),
    .pa_done(pa_done),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_z3(pa_z3), .pa_t3(pa_t3)
  );

  assign pa_done = stubDone | strayDone;

  // Stub point_add: done arrives LAT+1 cycles after the issue cycle, result is a plain sum
  always @(posedge clk) begin
    stubDone <= (stubCnt == 1);
    if (stubCnt != 0) stubCnt <= stubCnt - 1;
    if (pa_start) begin
      if (stubCnt != 0 || stubDone) protoErr <= protoErr + 1;
      stubCnt   <= LAT;
      stubCalls <= stubCalls + 1;
      pa_x3 <= pa_x1 + pa_x2;
      pa_y3 <= pa_y1 + pa_y2;
      pa_z3 <= pa_z1 + pa_z2;
      pa_t3 <= pa_t1 + pa_t2;
    end
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Under an additive stub, MSB-first Horner doubling/adding collapses to n*2^NBITS + k*b
  function automatic logic [W-1:0] refCoord(input logic [NBITS-1:0] kv, input logic [W-1:0] bv,
                                            input logic [W-1:0] nv);
    logic [2*W-1:0] wide;
    wide = ({{W{1'b0}}, nv} << NBITS) + {{W{1'b0}}, kv} * {{W{1'b0}}, bv};
    return wide[W-1:0];
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic applyStimulus(input string name, input logic [NBITS-1:0] kv,
                               input logic [W-1:0] vx, input logic [W-1:0] vy,
                               input logic [W-1:0] vz, input logic [W-1:0] vt,
                               input int glitchAt, input bit finGlitch);
    int cycles, calls0, busyLow, pop;
    bit seen;
    pop = $countones(kv);
    @(negedge clk);
    k = kv; bx = vx; by = vy; bz = vz; bt = vt; start = 1'b1;
    calls0 = stubCalls; cycles = 1; busyLow = 0; seen = 0;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      cycles++;
      if (c == 0) begin
        start = 1'b0; k = ~kv; bx = ~vx; by = ~vy; bz = ~vz; bt = ~vt;
      end
      if (c == glitchAt) begin
        start = 1'b1; k = randWide(); bx = randWide();
      end else if (c == glitchAt + 1) begin
        start = 1'b0;
      end
      if (!busy) busyLow++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    checkOutput({name, "_done_seen"}, W'(seen), W'(1));
    if (seen) begin
      checkOutput({name, "_rx"}, rx, refCoord(kv, vx, W'(0)));
      checkOutput({name, "_ry"}, ry, refCoord(kv, vy, W'(1)));
      checkOutput({name, "_rz"}, rz, refCoord(kv, vz, W'(1)));
      checkOutput({name, "_rt"}, rt, refCoord(kv, vt, W'(0)));
      checkOutput({name, "_calls"}, W'(stubCalls - calls0), W'(NBITS + pop));
      checkOutput({name, "_cycles"}, W'(cycles), W'(LAT * (NBITS + pop) + 3 * NBITS + 2 * pop + 2));
      checkOutput({name, "_busy_gap"}, W'(busyLow), W'(0));
      if (finGlitch) begin
        start = 1'b1; k = randWide();
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, "_done_pulse"}, W'(done), W'(0));
      checkOutput({name, "_busy_drop"}, W'(busy), W'(0));
    end
  endtask

  task automatic resetMidRun(input logic [NBITS-1:0] kv);
    int calls0, target, busyHigh;
    bit reached;
    target = (NBITS - 100) + $countones(kv[NBITS-1:101]);
    @(negedge clk);
    k = kv; bx = randWide(); by = randWide(); bz = randWide(); bt = randWide(); start = 1'b1;
    calls0 = stubCalls; reached = 0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      if (stubCalls - calls0 == target) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rst_reach_bit100", W'(reached), W'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_pa_start", W'(pa_start), W'(0));
    checkOutput("rst_done", W'(done), W'(0));
    checkOutput("rst_rx", rx, W'(0));
    checkOutput("rst_ry", ry, W'(0));
    checkOutput("rst_pa_x1", pa_x1, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    strayDone = 1'b1;
    @(negedge clk);
    strayDone = 1'b0;
    busyHigh = 0;
    for (int c = 0; c < 2 * LAT + 4; c++) begin
      @(negedge clk);
      if (busy || done || pa_start) busyHigh++;
    end
    checkOutput("rst_stray_ignored", W'(busyHigh), W'(0));
  endtask

  initial begin
    logic [NBITS-1:0] kr;
    rst_n = 1'b0; start = 1'b0; k = '0; bx = '0; by = '0; bz = '0; bt = '0;
    #23;
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_done", W'(done), W'(0));
    checkOutput("reset_pa_start", W'(pa_start), W'(0));
    checkOutput("reset_rx", rx, W'(0));
    checkOutput("reset_rz", rz, W'(0));
    checkOutput("reset_pa_y1", pa_y1, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("k0", '0, W'(3), W'(5), W'(7), W'(9), -1, 0);
    applyStimulus("k1", NBITS'(1), W'(3), W'(5), W'(7), W'(9), -1, 0);
    applyStimulus("kones", '1, randWide(), randWide(), randWide(), randWide(), -1, 0);
    for (int r = 0; r < 3; r++) begin
      kr = randWide();
      applyStimulus("krand", kr, randWide(), randWide(), randWide(), randWide(), -1, 0);
    end
    applyStimulus("kglitch", randWide(), randWide(), randWide(), randWide(), randWide(),
                  int'($urandom_range(50, 1500)), 0);
    applyStimulus("kfin", NBITS'(37), randWide(), randWide(), randWide(), randWide(), -1, 1);
    resetMidRun(randWide());
    applyStimulus("kafter", randWide(), randWide(), randWide(), randWide(), randWide(), -1, 0);

    checkOutput("protocol_errors", W'(protoErr), W'(0));
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
